trace_readout: RTL and testbench

- Reader side of the capture trace memory: after capture completes, the host starts a readout and this block fetches sample packets from the trace RAM read port, oldest first, wrapping around the circular buffer.
- Packets are presented two at a time on four host-visible byte registers.
- Advancement is by a host acknowledge handshake.
- Sits between the trace RAM and the host register file, alongside the capture top; its status byte is OR-visible next to the capture status.

---
 rtl/trace_readout.sv | 171 +++++++++++++++++
 tb/tb_trace_readout.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_readout.sv
// Trace RAM reader: after a start edge, fetches packets oldest-first around the circular buffer
// and presents them in pairs on four byte registers, advancing on each host_ack rising edge.
module trace_readout #(
  parameter int ADDR_WIDTH          = 10,
  parameter int SAMPLE_PACKET_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start_readout,
  input  logic                           abort,
  input  logic                           host_ack,
  input  logic [ADDR_WIDTH-1:0]          start_addr,
  input  logic [ADDR_WIDTH:0]            read_count,
  output logic                           mem_rd_en,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  input  logic [SAMPLE_PACKET_WIDTH-1:0] mem_rd_data,
  output logic [7:0]                     traceData_0,
  output logic [7:0]                     traceData_1,
  output logic [7:0]                     traceData_2,
  output logic [7:0]                     traceData_3,
  output logic [7:0]                     status
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH0,
    S_FETCH1,
    S_CAPTURE,
    S_PRESENT,
    S_DONE
  } state_t;

  localparam logic [ADDR_WIDTH:0] C_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t                         r_state;
  logic                           r_start_prev;
  logic                           r_ack_prev;
  logic                           r_start_go;
  logic [ADDR_WIDTH-1:0]          r_cur_addr;
  logic [ADDR_WIDTH:0]            r_remaining;
  logic [SAMPLE_PACKET_WIDTH-1:0] r_pkt0;
  logic [7:0]                     r_td0;
  logic [7:0]                     r_td1;
  logic [7:0]                     r_td2;
  logic [7:0]                     r_td3;
  logic                           r_busy;
  logic                           r_dv;
  logic                           r_done;
  logic                           r_pair_full;
  logic                           r_mem_rd_en;
  logic [ADDR_WIDTH-1:0]          r_mem_addr;

  logic                           w_start_edge;
  logic                           w_ack_edge;
  logic [ADDR_WIDTH:0]            w_count;

  assign w_start_edge = start_readout & ~r_start_prev;
  assign w_ack_edge   = host_ack & ~r_ack_prev;
  assign w_count      = (read_count > C_DEPTH) ? C_DEPTH : read_count;

  // The start edge only latches address/count; the FSM acts on it one edge later,
  // which puts the first read one cycle after the edge is seen.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_start_prev <= 1'b0;
      r_ack_prev   <= 1'b0;
      r_start_go   <= 1'b0;
      r_cur_addr   <= '0;
      r_remaining  <= '0;
      r_pkt0       <= '0;
      r_td0        <= 8'h00;
      r_td1        <= 8'h00;
      r_td2        <= 8'h00;
      r_td3        <= 8'h00;
      r_busy       <= 1'b0;
      r_dv         <= 1'b0;
      r_done       <= 1'b0;
      r_pair_full  <= 1'b0;
      r_mem_rd_en  <= 1'b0;
      r_mem_addr   <= '0;
    end else begin
      r_start_prev <= start_readout;
      r_ack_prev   <= host_ack;
      r_start_go   <= 1'b0;
      r_mem_rd_en  <= 1'b0;
      if (abort) begin
        r_state     <= S_IDLE;
        r_busy      <= 1'b0;
        r_dv        <= 1'b0;
        r_done      <= 1'b0;
        r_pair_full <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE, S_DONE: begin
            if (r_start_go) begin
              if (r_remaining == '0) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state     <= S_FETCH0;
                r_done      <= 1'b0;
                r_busy      <= 1'b1;
                r_mem_rd_en <= 1'b1;
                r_mem_addr  <= r_cur_addr;
              end
            end else if (w_start_edge) begin
              r_cur_addr  <= start_addr;
              r_remaining <= w_count;
              r_start_go  <= 1'b1;
            end
          end
          S_FETCH0: begin
            r_cur_addr  <= r_cur_addr + 1'b1;
            r_remaining <= r_remaining - 1'b1;
            r_state     <= S_FETCH1;
            // Second read of the pair goes out while the first word returns.
            if (r_remaining > 1) begin
              r_mem_rd_en <= 1'b1;
              r_mem_addr  <= r_cur_addr + 1'b1;
            end
          end
          S_FETCH1: begin
            r_pkt0  <= mem_rd_data;
            r_state <= S_CAPTURE;
            if (r_remaining != '0) begin
              r_cur_addr  <= r_cur_addr + 1'b1;
              r_remaining <= r_remaining - 1'b1;
              r_pair_full <= 1'b1;
            end else begin
              r_pair_full <= 1'b0;
            end
          end
          S_CAPTURE: begin
            r_td0   <= r_pkt0[7:0];
            r_td1   <= r_pkt0[15:8];
            r_td2   <= r_pair_full ? mem_rd_data[7:0]  : 8'h00;
            r_td3   <= r_pair_full ? mem_rd_data[15:8] : 8'h00;
            r_dv    <= 1'b1;
            r_state <= S_PRESENT;
          end
          S_PRESENT: begin
            if (w_ack_edge) begin
              r_dv        <= 1'b0;
              r_pair_full <= 1'b0;
              if (r_remaining != '0) begin
                r_state     <= S_FETCH0;
                r_mem_rd_en <= 1'b1;
                r_mem_addr  <= r_cur_addr;
              end else begin
                r_state <= S_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign mem_rd_en   = r_mem_rd_en;
  assign mem_addr    = r_mem_addr;
  assign traceData_0 = r_td0;
  assign traceData_1 = r_td1;
  assign traceData_2 = r_td2;
  assign traceData_3 = r_td3;
  assign status      = {4'b0000, r_pair_full, r_done, r_dv, r_busy};

endmodule

// File: tb/tb_trace_readout.sv
// Directed bench for trace_readout: a behavioural trace RAM returns 0xA000+addr one cycle after
// each read, and every read address is logged for ordering and count checks.
module tb_trace_readout;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_readout;
  logic        abort;
  logic        host_ack;
  logic [9:0]  start_addr;
  logic [10:0] read_count;
  logic        mem_rd_en;
  logic [9:0]  mem_addr;
  logic [15:0] mem_rd_data = 16'h0000;
  logic [7:0]  traceData_0, traceData_1, traceData_2, traceData_3;
  logic [7:0]  status;

  int errors = 0;
  int checks = 0;
  logic [9:0] rd_q[$];
  int base;

  trace_readout #(.ADDR_WIDTH(10), .SAMPLE_PACKET_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start_readout(start_readout), .abort(abort),
    .host_ack(host_ack), .start_addr(start_addr), .read_count(read_count),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .traceData_0(traceData_0), .traceData_1(traceData_1),
    .traceData_2(traceData_2), .traceData_3(traceData_3), .status(status)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rd_data <= 16'hA000 + {6'b0, mem_addr};
      rd_q.push_back(mem_addr);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_ack();
    host_ack = 1'b1;
    tick();
    host_ack = 1'b0;
  endtask

  task automatic wait_present();
    for (int i = 0; i < 20; i++) begin
      if (status[1]) break;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start_readout = 1'b0; abort = 1'b0; host_ack = 1'b0;
    start_addr = '0; read_count = '0;
    tick(); tick();
    checks++;
    if (status !== 8'h00 || mem_rd_en !== 1'b0 || mem_addr !== 10'h000) begin
      errors++; $display("FAIL reset_ctrl status=%h rd_en=%b addr=%h, want 00/0/000", status, mem_rd_en, mem_addr);
    end
    checks++;
    if ({traceData_3, traceData_2, traceData_1, traceData_0} !== 32'h0) begin
      errors++; $display("FAIL reset_data got=%h want=00000000", {traceData_3, traceData_2, traceData_1, traceData_0});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    base = rd_q.size();
    start_addr = 10'h010; read_count = 11'd4; start_readout = 1'b1;
    tick();  // edge k
    checks++;
    if (mem_rd_en !== 1'b0) begin
      errors++; $display("FAIL basic_no_rd_at_k rd_en=%b want=0", mem_rd_en);
    end
    start_readout = 1'b0;
    tick();  // k+1
    checks++;
    if (mem_rd_en !== 1'b1 || mem_addr !== 10'h010) begin
      errors++; $display("FAIL basic_first_rd rd_en=%b addr=%h want 1/010", mem_rd_en, mem_addr);
    end
    tick(); tick();  // k+3
    checks++;
    if (status !== 8'h09) begin
      errors++; $display("FAIL basic_pre_valid status=%h want=09", status);
    end
    tick();  // k+4
    checks++;
    if (status !== 8'h0B) begin
      errors++; $display("FAIL basic_status1 status=%h want=0B", status);
    end
    checks++;
    if ({traceData_1, traceData_0, traceData_3, traceData_2} !== 32'hA010_A011) begin
      errors++; $display("FAIL basic_pair1 got=%h want=A010A011", {traceData_1, traceData_0, traceData_3, traceData_2});
    end
    do_ack();  // ack edge a
    checks++;
    if (status !== 8'h01) begin
      errors++; $display("FAIL basic_after_ack status=%h want=01", status);
    end
    tick(); tick(); tick();  // a+3
    checks++;
    if (status !== 8'h0B || {traceData_1, traceData_0, traceData_3, traceData_2} !== 32'hA012_A013) begin
      errors++; $display("FAIL basic_pair2 status=%h data=%h want 0B/A012A013", status,
                         {traceData_1, traceData_0, traceData_3, traceData_2});
    end
    do_ack();
    checks++;
    if (status !== 8'h04) begin
      errors++; $display("FAIL basic_done status=%h want=04", status);
    end
    checks++;
    if (rd_q.size() - base != 4 || rd_q[base] !== 10'h010 || rd_q[base+1] !== 10'h011 ||
        rd_q[base+2] !== 10'h012 || rd_q[base+3] !== 10'h013) begin
      errors++; $display("FAIL basic_reads count=%0d want 4 reads 010..013", rd_q.size() - base);
    end
  endtask

  task automatic test_wrap();
    base = rd_q.size();
    start_addr = 10'h3FE; read_count = 11'd4; start_readout = 1'b1;
    tick();
    start_readout = 1'b0;
    wait_present();
    checks++;
    if ({traceData_1, traceData_0, traceData_3, traceData_2} !== 32'hA3FE_A3FF) begin
      errors++; $display("FAIL wrap_pair1 got=%h want=A3FEA3FF", {traceData_1, traceData_0, traceData_3, traceData_2});
    end
    do_ack();
    wait_present();
    checks++;
    if ({traceData_1, traceData_0, traceData_3, traceData_2} !== 32'hA000_A001) begin
      errors++; $display("FAIL wrap_pair2 got=%h want=A000A001", {traceData_1, traceData_0, traceData_3, traceData_2});
    end
    do_ack();
    checks++;
    if (rd_q.size() - base != 4 || rd_q[base] !== 10'h3FE || rd_q[base+1] !== 10'h3FF ||
        rd_q[base+2] !== 10'h000 || rd_q[base+3] !== 10'h001) begin
      errors++; $display("FAIL wrap_addrs count=%0d want 4 reads 3FE,3FF,000,001", rd_q.size() - base);
    end
  endtask

  task automatic test_odd();
    base = rd_q.size();
    start_addr = 10'h020; read_count = 11'd3; start_readout = 1'b1;
    tick();
    start_readout = 1'b0;
    wait_present();
    checks++;
    if (status !== 8'h0B || {traceData_1, traceData_0, traceData_3, traceData_2} !== 32'hA020_A021) begin
      errors++; $display("FAIL odd_pair1 status=%h data=%h want 0B/A020A021", status,
                         {traceData_1, traceData_0, traceData_3, traceData_2});
    end
    do_ack();
    wait_present();
    checks++;
    if (status !== 8'h03 || {traceData_1, traceData_0, traceData_3, traceData_2} !== 32'hA022_0000) begin
      errors++; $display("FAIL odd_half_pair status=%h data=%h want 03/A0220000", status,
                         {traceData_1, traceData_0, traceData_3, traceData_2});
    end
    do_ack();
    checks++;
    if (status !== 8'h04 || rd_q.size() - base != 3) begin
      errors++; $display("FAIL odd_done status=%h reads=%0d want 04/3", status, rd_q.size() - base);
    end
  endtask

  task automatic test_zero();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (status !== 8'h00) begin
      errors++; $display("FAIL zero_abort_done status=%h want=00", status);
    end
    base = rd_q.size();
    start_addr = 10'h055; read_count = 11'd0; start_readout = 1'b1;
    tick();  // edge k
    tick();  // k+1
    checks++;
    if (status !== 8'h04) begin
      errors++; $display("FAIL zero_done status=%h want=04", status);
    end
    read_count = 11'd2;  // start held high: no new edge, no readout
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (status !== 8'h04 || rd_q.size() != base) begin
      errors++; $display("FAIL zero_held_start status=%h reads=%0d want 04/0", status, rd_q.size() - base);
    end
    start_readout = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    base = rd_q.size();
    start_addr = 10'h100; read_count = 11'd6; start_readout = 1'b1;
    tick();
    start_readout = 1'b0;
    wait_present();
    checks++;
    if ({traceData_1, traceData_0, traceData_3, traceData_2} !== 32'hA100_A101) begin
      errors++; $display("FAIL abort_pair1 got=%h want=A100A101", {traceData_1, traceData_0, traceData_3, traceData_2});
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (status !== 8'h00 || {traceData_1, traceData_0} !== 16'hA100) begin
      errors++; $display("FAIL abort_status status=%h td=%h want 00/A100", status, {traceData_1, traceData_0});
    end
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (rd_q.size() - base != 2) begin
      errors++; $display("FAIL abort_no_reads reads=%0d want=2", rd_q.size() - base);
    end
    start_addr = 10'h200; read_count = 11'd2; start_readout = 1'b1;
    tick();
    start_readout = 1'b0;
    wait_present();
    checks++;
    if ({traceData_1, traceData_0, traceData_3, traceData_2} !== 32'hA200_A201 || rd_q.size() - base != 4) begin
      errors++; $display("FAIL abort_restart data=%h reads=%0d want A200A201/4",
                         {traceData_1, traceData_0, traceData_3, traceData_2}, rd_q.size() - base);
    end
    do_ack();
  endtask

  task automatic test_ack_ignored();
    start_addr = 10'h030; read_count = 11'd2; start_readout = 1'b1;
    tick();  // k
    start_readout = 1'b0;
    tick();  // k+1: FETCH0 from here
    host_ack = 1'b1;
    tick();  // k+2: edge seen in FETCH0
    host_ack = 1'b0;
    tick();  // k+3
    tick();  // k+4
    checks++;
    if (status !== 8'h0B || {traceData_1, traceData_0, traceData_3, traceData_2} !== 32'hA030_A031) begin
      errors++; $display("FAIL ackign_present status=%h data=%h want 0B/A030A031", status,
                         {traceData_1, traceData_0, traceData_3, traceData_2});
    end
    tick(); tick();
    checks++;
    if (status !== 8'h0B) begin
      errors++; $display("FAIL ackign_not_queued status=%h want=0B", status);
    end
    do_ack();
    checks++;
    if (status !== 8'h04) begin
      errors++; $display("FAIL ackign_done status=%h want=04", status);
    end
  endtask

  task automatic test_reset_mid();
    start_addr = 10'h040; read_count = 11'd2; start_readout = 1'b1;
    tick();  // k
    start_readout = 1'b0;
    tick(); tick(); tick();  // k+3: CAPTURE
    checks++;
    if (status !== 8'h09) begin
      errors++; $display("FAIL rstmid_capture status=%h want=09", status);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (status !== 8'h00 || mem_rd_en !== 1'b0 ||
        {traceData_3, traceData_2, traceData_1, traceData_0} !== 32'h0) begin
      errors++; $display("FAIL rstmid_cleared status=%h rd_en=%b data=%h want 00/0/00000000", status, mem_rd_en,
                         {traceData_3, traceData_2, traceData_1, traceData_0});
    end
    tick(); tick();
    checks++;
    if (status !== 8'h00) begin
      errors++; $display("FAIL rstmid_stays_idle status=%h want=00", status);
    end
  endtask

  initial begin
    reset = 1'b1; start_readout = 1'b0; abort = 1'b0; host_ack = 1'b0;
    start_addr = '0; read_count = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_wrap();
    test_odd();
    test_zero();
    test_abort();
    test_ack_ignored();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
